// File: rtl/seq_multiplier_32b_pkg.sv
// Shared constants and FSM encoding for the sequential shift-add multiplier.
package seq_multiplier_32b_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_e;

   // Counter must hold values 0..width-1 with one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width) + 1;
   endfunction

   localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/seq_multiplier_32b_if.sv
// Request/response bundle between a multiply requester and seq_multiplier_32b.
interface seq_multiplier_32b_if
   import seq_multiplier_32b_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);

   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   result;

   modport master (
      output start, a, b,
      input  busy, done, product, result
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, result
   );

endinterface

// File: rtl/seq_multiplier_32b_adder.sv
// Partial-sum adder: WIDTH-bit unsigned add with carry-out.
module adder_32b #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   assign {carry, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_multiplier_32b.sv
// Sequential unsigned multiplier: one shift-add step per cycle, WIDTH steps per product.
module seq_multiplier_32b
   import seq_multiplier_32b_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input logic                clk,
   input logic                rst_n,
   seq_multiplier_32b_if.slave bus
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   state_e               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [CntW-1:0]      cnt_q;
   logic                 busy_q;
   logic                 done_q;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic                 carry;
   logic [2*WIDTH-1:0]   acc_d;
   logic                 last_step;

   assign addend = mplier_q[0] ? mcand_q : '0;

   adder_32b #(
      .WIDTH (WIDTH)
   ) u_adder (
      .x     (acc_q[2*WIDTH-1:WIDTH]),
      .y     (addend),
      .sum   (sum),
      .carry (carry)
   );

   // Carry-out becomes the new MSB; the bit leaving the upper half lands in the lower half.
   assign acc_d     = {carry, sum, acc_q[WIDTH-1:1]};
   assign last_step = (cnt_q == CntW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  mcand_q  <= bus.a;
                  mplier_q <= bus.b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StCalc;
               end else begin
                  state_q  <= StIdle;
               end
            end
            StCalc: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (last_step) begin
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.result  = product_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier_32b.sv
// Self-checking bench for seq_multiplier_32b against a plain-arithmetic product model.
module tb_seq_multiplier_32b;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seq_multiplier_32b_if bus ();

   seq_multiplier_32b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      longint unsigned p;
      p = longint'(x) * longint'(y);
      return 64'(p);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated multiply: start in cycle 0, operands scrambled right after accept.
   task automatic mul_op(input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [63:0] exp;
      logic [63:0] prev;
      int          cyc;
      int          busy_cnt;
      logic        stable;
      exp      = ref_mul(x, y);
      prev     = bus.product;
      bus.a    = x;
      bus.b    = y;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a    = $urandom;
      bus.b    = $urandom;
      cyc      = 1;
      busy_cnt = 0;
      stable   = 1'b1;
      while (!bus.done && cyc < 100) begin
         if (bus.busy) busy_cnt++;
         if (bus.product !== prev) stable = 1'b0;
         tick();
         cyc++;
      end
      check_val({tag, "_done_cycle"}, 64'(cyc), 64'd33);
      check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check_val({tag, "_hold_in_calc"}, 64'(stable), 64'd1);
      check_val({tag, "_product"}, bus.product, exp);
      check_val({tag, "_result"}, 64'(bus.result), 64'(exp[31:0]));
      check_val({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
      tick();
      check_val({tag, "_done_single"}, 64'(bus.done), 64'd0);
      check_val({tag, "_product_held"}, bus.product, exp);
   endtask

   initial begin
      int          cyc;
      int          dones;
      int          d1;
      int          d2;
      logic        gap_busy;
      logic [63:0] p1;
      logic [63:0] p2;
      logic [31:0] rx;
      logic [31:0] ry;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #22;
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_product", bus.product, 64'd0);
      check_val("rst_result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      mul_op(32'd3, 32'd5, "small");
      mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
      mul_op(32'd0, 32'h1234_5678, "zero_a");
      mul_op(32'h8000_0001, 32'd0, "zero_b");
      for (int i = 0; i < 8; i++) begin
         rx = $urandom;
         ry = $urandom;
         if (i == 3) ry = 32'h8000_0000;
         mul_op(rx, ry, "rand");
      end

      // Second start during CALC must be ignored.
      bus.a = 32'd7;
      bus.b = 32'd6;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      dones = 0;
      d1 = 0;
      p1 = '0;
      for (int c = 1; c <= 45; c++) begin
         if (bus.done) begin
            dones++;
            d1 = c;
            p1 = bus.product;
         end
         if (c == 10) begin
            bus.start = 1'b1;
            bus.a = 32'd9;
            bus.b = 32'd9;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      check_val("ignore_dones", 64'(dones), 64'd1);
      check_val("ignore_done_cycle", 64'(d1), 64'd33);
      check_val("ignore_product", p1, 64'd42);

      // Reset mid-CALC aborts the operation.
      bus.a = 32'd100;
      bus.b = 32'd200;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 15; c++) tick();
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", 64'(bus.busy), 64'd0);
      check_val("abort_product", bus.product, 64'd0);
      check_val("abort_result", 64'(bus.result), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done || bus.busy) dones++;
         tick();
      end
      check_val("abort_no_done", 64'(dones), 64'd0);
      mul_op(32'd2, 32'd2, "after_rst");

      // Back-to-back accept with start held high.
      bus.a = 32'd4;
      bus.b = 32'd5;
      bus.start = 1'b1;
      tick();
      cyc = 1;
      d1 = 0;
      d2 = 0;
      p1 = '0;
      p2 = '0;
      gap_busy = 1'b0;
      while (cyc < 120 && d2 == 0) begin
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = cyc;
               p1 = bus.product;
               bus.a = 32'd6;
               bus.b = 32'd7;
            end else begin
               d2 = cyc;
               p2 = bus.product;
               bus.start = 1'b0;
            end
         end else if (d1 != 0 && cyc == d1 + 1) begin
            gap_busy = bus.busy;
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      check_val("b2b_first_cycle", 64'(d1), 64'd33);
      check_val("b2b_gap", 64'(d2 - d1), 64'd33);
      check_val("b2b_first_product", p1, 64'd20);
      check_val("b2b_second_product", p2, 64'd42);
      check_val("b2b_no_idle", 64'(gap_busy), 64'd1);
      tick();
      check_val("b2b_idle_after", 64'(bus.busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier_32b.md
SEQ_MULTIPLIER_32B -- requirements
Module: seq_multiplier_32b

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-006 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-007 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking product valid.
REQ-009 SHALL have port product  output  2*WIDTH  full unsigned product, registered.
REQ-010 SHALL have port result  output  WIDTH  product[WIDTH-1:0]; the input to the ALU 32-bit result mux.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 In IDLE, start=1 SHALL latch a and b, clear accumulator and bit counter, and move to CALC.
REQ-013 In CALC, each cycle SHALL add the multiplicand to the accumulator upper half when the current multiplier LSB is 1, then shift right one bit, capturing the adder carry-out.
REQ-014 CALC SHALL last exactly WIDTH cycles, counted by a bit counter of width clog2(WIDTH)+1, then move to DONE.
REQ-015 On entry to DONE, product SHALL load the final accumulator value; done=1 for exactly that one cycle.
REQ-016 Latency: start sampled in cycle 0 SHALL give done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-017 From DONE, FSM SHALL go to CALC when start=1 (back-to-back accept, new operands latched), else to IDLE.
REQ-018 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored while in CALC; operands latched at accept SHALL be unaffected by later changes on a and b.
REQ-020 product and result SHALL hold their last value until the next completion; they SHALL NOT change during CALC.
REQ-021 Arithmetic SHALL be unsigned with no overflow; the 2*WIDTH product is exact for all inputs.
REQ-022 A zero operand SHALL still take the full WIDTH CALC cycles; there is no early termination.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, product=0, result=0, and clear the accumulator, operand and counter registers.
REQ-024 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-026 A shared package SHALL hold the WIDTH default, the FSM state encoding (2-bit: IDLE=00, CALC=01, DONE=10) and the counter-width constant.
REQ-027 The partial-sum add SHALL be one sub-module, adder_32b (WIDTH-bit add with carry-out); all other logic SHALL be inline.

Verification
REQ-028 a=3, b=5, start pulse -> done in cycle 33, product=15, result=15.
REQ-029 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, result=0x00000001.
REQ-030 a=0, b=0x12345678 -> done in cycle 33, product=0; busy high for exactly 32 cycles.
REQ-031 Start a=7, b=6; at cycle 10 pulse start with a=9, b=9 -> second start ignored; product=42; a single done pulse.
REQ-032 Start a=100, b=200; pull rst_n low at cycle 15 -> busy=0, product=0 immediately; no done pulse; next start with a=2, b=2 gives product=4.
REQ-033 Hold start=1 with a=4, b=5 then a=6, b=7 presented in the DONE cycle -> products 20 then 42, done pulses 33 cycles apart, no idle cycle between operations.
